alu_pipe: RTL

- Parametrised, handshaked successor to the single-cycle execute-stage ALU.
- Adds a registered result with valid/ready flow control, a 4-bit op field and new ops (SRA split from SRL, SLT, SLTU).
- Adds an iterative multiply op that is stalled behind an FSM.
- Sits between the ID/EX register and the EX/MEM register, so execute can stall on long ops.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and sizing helpers for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  function automatic int unsigned shamt_width(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: retires MUL_STEP multiplier bits per cycle and
// returns the low DATA_W bits of the product after DATA_W/MUL_STEP cycles.
module alu_mul_iter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MUL_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned N_MUL = DATA_W / MUL_STEP;
  localparam int unsigned CNT_W = (N_MUL > 1) ? $clog2(N_MUL) : 1;

  logic [DATA_W-1:0] acc, acc_next, a_sh, b_sh, partial;
  logic [CNT_W-1:0]  count;
  logic              busy;

  always_comb begin
    partial  = a_sh * DATA_W'(b_sh[MUL_STEP-1:0]);
    acc_next = acc + partial;
    done     = busy && (count == CNT_W'(N_MUL - 1));
    // Final partial product is folded in combinationally so done and product line up.
    product  = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      a_sh  <= a;
      b_sh  <= b;
      count <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= acc_next;
      a_sh  <= a_sh << MUL_STEP;
      b_sh  <= b_sh >> MUL_STEP;
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU with registered result. Define ALU_MUL_EN to build the
// iterative MUL op; otherwise opcode 1010 is treated as illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned MUL_STEP = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [3:0]        i_alu_control,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_zero,
  output logic              o_illegal,
  output logic [TAG_W-1:0]  o_tag
);

  localparam int unsigned SHAMT_W = shamt_width(DATA_W);

  logic               accept, idle, is_mul, mul_done, alu_illegal;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  alu_res, mul_product;
  logic [TAG_W-1:0]   mul_tag;

  assign shamt = i_data1[SHAMT_W-1:0];

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (i_alu_control)
      ALU_ADD:  alu_res = i_data0 + i_data1;
      ALU_SUB:  alu_res = i_data0 - i_data1;
      ALU_AND:  alu_res = i_data0 & i_data1;
      ALU_OR:   alu_res = i_data0 | i_data1;
      ALU_XOR:  alu_res = i_data0 ^ i_data1;
      ALU_SLL:  alu_res = i_data0 << shamt;
      ALU_SRL:  alu_res = i_data0 >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(i_data0) >>> shamt);
      ALU_SLT:  alu_res = DATA_W'($signed(i_data0) < $signed(i_data1));
      ALU_SLTU: alu_res = DATA_W'(i_data0 < i_data1);
      default:  alu_illegal = 1'b1;
    endcase
  end

  assign o_ready = idle && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;

`ifdef ALU_MUL_EN
  state_t state, state_next;

  assign is_mul = (i_alu_control == ALU_MUL);
  assign idle   = (state == S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_next = S_MUL;
      S_MUL:   if (mul_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                 mul_tag <= '0;
    else if (accept && is_mul) mul_tag <= i_tag;
  end

  alu_mul_iter #(
    .DATA_W  (DATA_W),
    .MUL_STEP(MUL_STEP)
  ) u_mul (
    .clk    (i_clk),
    .rst    (i_rst),
    .start  (accept && is_mul),
    .a      (i_data0),
    .b      (i_data1),
    .done   (mul_done),
    .product(mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign idle        = 1'b1;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign mul_tag     = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_zero    <= 1'b0;
      o_illegal <= 1'b0;
      o_tag     <= '0;
    end else if (accept && !is_mul) begin
      o_valid   <= 1'b1;
      o_data    <= alu_res;
      o_zero    <= (alu_res == '0);
      o_illegal <= alu_illegal;
      o_tag     <= i_tag;
    end else if (accept) begin
      // A MUL accept implies the held result drains this edge (or none was held).
      o_valid   <= 1'b0;
    end else if (mul_done) begin
      o_valid   <= 1'b1;
      o_data    <= mul_product;
      o_zero    <= (mul_product == '0);
      o_illegal <= 1'b0;
      o_tag     <= mul_tag;
    end else if (o_valid && i_ready) begin
      o_valid   <= 1'b0;
    end
  end

endmodule
